ser2par32: RTL

SER2PAR32 -- requirements
Module: ser2par32

---
 rtl/ser2par32_if.sv | 22 ++
 rtl/ser2par32.sv | 83 ++++++++
 2 files changed

// File: rtl/ser2par32_if.sv
// ser2par32 bus: serial input side plus parallel output handshake.
// master drives serial bits and ready; slave is the converter.
interface ser2par32_if #(
  parameter int WIDTH = 32
);
  logic             sin;
  logic             sin_valid;
  logic             dir;
  logic             po_ready;
  logic             po_valid;
  logic [WIDTH-1:0] po;

  modport master (
    output sin, sin_valid, dir, po_ready,
    input  po, po_valid
  );

  modport slave (
    input  sin, sin_valid, dir, po_ready,
    output po, po_valid
  );
endinterface

// File: rtl/ser2par32.sv
// ser2par32: serial-to-parallel word assembler with a held output
// register, valid/ready handshake, selectable bit order and overrun flag.
module ser2par32 #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  ser2par32_if.slave  bus,
  input  logic        clear,
  output logic        busy,
  output logic [5:0]  bit_cnt,
  output logic        overrun
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] asm_q;
  logic [WIDTH-1:0] po_q;
  logic [WIDTH-1:0] nxt;
  logic [5:0]       cnt_q;
  logic             ord_q;
  logic             pv_q;
  logic             ovr_q;
  logic             take;
  logic             last;
  logic             ord;

  // Next assembly value; the first bit of a word uses dir directly.
  always_comb begin
    take = bus.sin_valid & ~clear;
    ord  = (state == IDLE) ? bus.dir : ord_q;
    last = take && (cnt_q == 6'(WIDTH - 1));
    nxt  = ord ? {bus.sin, asm_q[WIDTH-1:1]}
               : {asm_q[WIDTH-2:0], bus.sin};
  end

  // Word FSM, assembly register and output holding stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      asm_q <= '0;
      cnt_q <= '0;
      ord_q <= 1'b0;
      po_q  <= '0;
      pv_q  <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      if (clear) begin
        state <= IDLE;
        asm_q <= '0;
        cnt_q <= '0;
        ovr_q <= 1'b0;
      end else if (take) begin
        if (state == IDLE) ord_q <= bus.dir;
        if (last) begin
          state <= IDLE;
          asm_q <= '0;
          cnt_q <= '0;
        end else begin
          state <= SHIFT;
          asm_q <= nxt;
          cnt_q <= cnt_q + 6'd1;
        end
      end
      if (last && (!pv_q || bus.po_ready)) begin
        po_q <= nxt;
        pv_q <= 1'b1;
      end else if (last) begin
        ovr_q <= 1'b1;
      end else if (pv_q && bus.po_ready) begin
        pv_q <= 1'b0;
      end
    end
  end

  assign bus.po       = po_q;
  assign bus.po_valid = pv_q;
  assign busy         = (state == SHIFT);
  assign bit_cnt      = cnt_q;
  assign overrun      = ovr_q;

endmodule
